// File: rtl/pixel_ring_scheduler.sv
// Type 30 CRT pixel ring sequencer: decays recirculating words, inserts queued pixels into free slots,
// and clears the ring after reset/flush. Define PIXEL_MERGE_EN to refresh lit pixels in place.
module pixel_ring_scheduler #(
  parameter int unsigned RING_LEN     = 8192,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned DECAY_PERIOD = 4,
  parameter int unsigned DECAY_STEP   = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic                        pixel_valid,
  output logic                        pixel_ready,
  input  logic [9:0]                  pixel_x,
  input  logic [9:0]                  pixel_y,
  input  logic [11:0]                 pixel_luma,
  input  logic [31:0]                 ring_shiftout,
  output logic [31:0]                 ring_shiftin,
  output logic [$clog2(RING_LEN)-1:0] ring_pos,
  output logic                        pass_done,
  output logic                        busy
);

  localparam int unsigned PW  = $clog2(RING_LEN);
  localparam int unsigned FAW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DW  = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

  localparam logic [PW-1:0] POS_LAST  = PW'(RING_LEN - 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DECAY_PERIOD - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
  localparam logic [11:0]   STEP      = 12'(DECAY_STEP);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [31:0]     shiftin_q, shiftin_d;
  logic            pass_q, pass_d;
  logic [FAW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FAW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     fifo_mem_q [FIFO_DEPTH];

  logic [31:0] head;
  logic        fifo_nempty;
  logic [11:0] o_luma;
  logic        dp;
  logic [11:0] decayed;
  logic        merge_hit;
  logic [11:0] merge_luma;
  logic        push;
  logic        pop;

  // FIFO entries use the ring word layout so the head can be written back unchanged.
  assign head        = fifo_mem_q[rd_ptr_q];
  assign fifo_nempty = (count_q != '0);
  assign o_luma      = ring_shiftout[31:20];
  assign dp          = (dcnt_q == DCNT_LAST);
  assign push        = pixel_valid && pixel_ready && (pixel_luma != '0) && !flush;

  always_comb begin
    decayed = o_luma;
    if (dp) begin
      decayed = (o_luma > STEP) ? (o_luma - STEP) : '0;
    end
  end

`ifdef PIXEL_MERGE_EN
  always_comb begin
    merge_hit  = fifo_nempty && (o_luma != '0) && (head[19:0] == ring_shiftout[19:0]);
    merge_luma = (decayed > head[31:20]) ? decayed : head[31:20];
  end
`else
  always_comb begin
    merge_hit  = 1'b0;
    merge_luma = '0;
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_CLEAR;
      pos_q     <= '0;
      dcnt_q    <= '0;
      shiftin_q <= '0;
      pass_q    <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      dcnt_q    <= dcnt_d;
      shiftin_q <= shiftin_d;
      pass_q    <= pass_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {pixel_luma, pixel_y, pixel_x};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CLEAR: if (pos_q == POS_LAST) state_d = ST_RUN;
      ST_RUN:   if (flush)             state_d = ST_CLEAR;
      default:                         state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    pos_d     = pos_q + PW'(1);
    dcnt_d    = dcnt_q;
    shiftin_d = '0;
    pass_d    = 1'b0;
    pop       = 1'b0;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    if (state_q == ST_CLEAR) begin
      dcnt_d = '0;
    end else if (flush) begin
      pos_d    = '0;
      dcnt_d   = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (merge_hit) begin
        shiftin_d = {merge_luma, ring_shiftout[19:0]};
        pop       = 1'b1;
      end else if ((decayed == '0) && fifo_nempty) begin
        shiftin_d = head;
        pop       = 1'b1;
      end else if (decayed != '0) begin
        shiftin_d = {decayed, ring_shiftout[19:0]};
      end
      pass_d = (pos_q == POS_LAST);
      if (pass_d) begin
        dcnt_d = dp ? '0 : dcnt_q + DW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + FAW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + FAW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_comb begin
    pixel_ready = (state_q == ST_RUN) && (count_q < FIFO_FULL);
    busy        = (state_q == ST_CLEAR);
  end

  assign ring_shiftin = shiftin_q;
  assign ring_pos     = pos_q;
  assign pass_done    = pass_q;

endmodule

// File: tb/tb_pixel_ring_scheduler.sv
// Bench for pixel_ring_scheduler: the bench owns the ring storage and a reference model whose
// predictions are queued at drive time and compared when the registered outputs appear.
module tb_pixel_ring_scheduler;

  localparam int unsigned L  = 16;
  localparam int unsigned FD = 4;
  localparam int unsigned DP = 2;
  localparam int unsigned DS = 16;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [11:0] pixel_luma;
  logic [31:0] ring_shiftout;
  logic [31:0] ring_shiftin;
  logic [3:0]  ring_pos;
  logic        pass_done;
  logic        busy;

  pixel_ring_scheduler #(
    .RING_LEN    (L),
    .FIFO_DEPTH  (FD),
    .DECAY_PERIOD(DP),
    .DECAY_STEP  (DS)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (flush),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .pixel_luma   (pixel_luma),
    .ring_shiftout(ring_shiftout),
    .ring_shiftin (ring_shiftin),
    .ring_pos     (ring_pos),
    .pass_done    (pass_done),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] ex_shiftin;
    logic [3:0]  ex_pos;
    logic        ex_pass;
    logic        ex_busy;
    logic        ex_ready;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] ring [L];
  logic [31:0] m_fifo [$];
  bit          m_run;
  bit          m_pass;
  int unsigned m_pos;
  int unsigned m_dcnt;
  int unsigned cyc;
  int          n_checks;
  int          n_pass;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
  endtask

  // One clock: drive inputs, advance the model, then compare the registered outputs.
  task automatic step(input bit f, input bit v, input logic [9:0] x, input logic [9:0] y,
                      input logic [11:0] l, input bit inj, input logic [31:0] iv);
    int unsigned idx, ol, d, hl;
    logic [31:0] o, ns, h;
    bit          rdy, mhit;
    exp_t        e;
    idx = cyc % L;
    o   = !m_run ? 32'hFFFF_FFFF : (inj ? iv : ring[idx]);
    flush         = f;
    pixel_valid   = v;
    pixel_x       = x;
    pixel_y       = y;
    pixel_luma    = l;
    ring_shiftout = o;
    rdy = m_run && (m_fifo.size() < FD);
    ns  = '0;
    if (!m_run) begin
      m_pass = 0;
      m_dcnt = 0;
      if (m_pos == L - 1) begin
        m_run = 1;
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end else if (f) begin
      m_run  = 0;
      m_pos  = 0;
      m_dcnt = 0;
      m_pass = 0;
      m_fifo.delete();
    end else begin
      ol = o[31:20];
      d  = ol;
      if (m_dcnt == DP - 1) d = (ol >= DS) ? ol - DS : 0;
      h    = (m_fifo.size() > 0) ? m_fifo[0] : '0;
      hl   = h[31:20];
      mhit = 0;
`ifdef PIXEL_MERGE_EN
      mhit = (m_fifo.size() > 0) && (ol != 0) && (h[19:0] == o[19:0]);
`endif
      if (mhit) begin
        ns = {12'(d > hl ? d : hl), o[19:0]};
        void'(m_fifo.pop_front());
      end else if (d == 0 && m_fifo.size() > 0) begin
        ns = h;
        void'(m_fifo.pop_front());
      end else if (d != 0) begin
        ns = {12'(d), o[19:0]};
      end
      if (v && rdy && l != 0) m_fifo.push_back({l, y, x});
      m_pass = (m_pos == L - 1);
      if (m_pass) m_dcnt = (m_dcnt + 1) % DP;
      m_pos = (m_pos + 1) % L;
    end
    ring[idx]    = ns;
    e.ex_shiftin = ns;
    e.ex_pos     = 4'(m_pos);
    e.ex_pass    = m_pass;
    e.ex_busy    = !m_run;
    e.ex_ready   = m_run && (m_fifo.size() < FD);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check_eq("shiftin",     ring_shiftin,      e.ex_shiftin);
    check_eq("ring_pos",    32'(ring_pos),     32'(e.ex_pos));
    check_eq("pass_done",   32'(pass_done),    32'(e.ex_pass));
    check_eq("busy",        32'(busy),         32'(e.ex_busy));
    check_eq("pixel_ready", 32'(pixel_ready),  32'(e.ex_ready));
    cyc++;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(0, 0, '0, '0, '0, 0, '0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    m_run    = 0;
    m_pass   = 0;
    m_pos    = 0;
    m_dcnt   = 0;
    for (int unsigned i = 0; i < L; i++) ring[i] = '0;
    reset_n       = 1'b0;
    flush         = 1'b0;
    pixel_valid   = 1'b0;
    pixel_x       = '0;
    pixel_y       = '0;
    pixel_luma    = '0;
    ring_shiftout = 32'hFFFF_FFFF;

    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_shiftin", ring_shiftin,      32'h0);
    check_eq("rst_pos",     32'(ring_pos),     32'h0);
    check_eq("rst_busy",    32'(busy),         32'h1);
    check_eq("rst_ready",   32'(pixel_ready),  32'h0);
    check_eq("rst_pass",    32'(pass_done),    32'h0);
    reset_n = 1'b1;

    // Clear pass with the ring output held at all ones.
    idle(L);
    check_eq("clear_done_busy",  32'(busy),        32'h0);
    check_eq("clear_done_ready", 32'(pixel_ready), 32'h1);

    // Insert into an empty ring.
    step(0, 1, 10'd5, 10'd7, 12'hFFF, 0, '0);
    step(0, 0, '0, '0, '0, 0, '0);
    check_eq("insert_word", ring_shiftin, 32'hFFF0_1C05);

    // Decay and expiry of a dim word.
    step(0, 0, '0, '0, '0, 1, {12'h020, 10'd2, 10'd3});
    idle(6 * L);

    // Backpressure: every slot lit, four pixels queued, a fifth offered.
    for (int unsigned k = 0; k < L; k++) begin
      step(0, k < 5, 10'(k + 40), 10'd1, 12'(12'h100 + k), 1, {12'h040, 10'd9, 10'(k)});
      if (k == 3) check_eq("bp_ready_low", 32'(pixel_ready), 32'h0);
    end
    check_eq("bp_ready_still_low", 32'(pixel_ready), 32'h0);
    idle(12 * L);

    // Flush with two pixels queued behind a lit ring.
    for (int unsigned k = 0; k < L; k++)
      step(0, k < 2, 10'(k + 60), 10'd2, 12'h300, 1, {12'h080, 10'd4, 10'(k)});
    step(1, 1, 10'd99, 10'd3, 12'h200, 0, '0);
    check_eq("flush_busy", 32'(busy),     32'h1);
    check_eq("flush_pos",  32'(ring_pos), 32'h0);
    idle(3 * L);

    // Re-draw of a lit coordinate.
    for (int unsigned k = 0; k < L; k++)
      step(0, k == 0, 10'd5, 10'd7, 12'h800, 1,
           (k == 8) ? {12'h100, 10'd7, 10'd5} : {12'h040, 10'd1, 10'(k + 20)});
    idle(40 * L);

    // Mixed random traffic over a small coordinate space.
    for (int unsigned i = 0; i < 2000; i++) begin
      int unsigned r;
      logic [11:0] lr;
      r  = $urandom_range(0, 7);
      lr = (r == 0) ? 12'h0 : 12'(r * 16 + $urandom_range(0, 15));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
           10'($urandom_range(0, 3)), 10'($urandom_range(0, 3)), lr,
           $urandom_range(0, 15) == 0,
           {12'($urandom_range(0, 255)), 10'($urandom_range(0, 3)), 10'($urandom_range(0, 3))});
    end
    idle(L);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
